// File: rtl/regfile_writeback_unit.sv
// Registered write-back stage between the MEM stage and the GPR write port.
// It picks the GPR write index and data, extracts sub-word loads with sign or
// zero extension, owns the LO/HI registers, and tracks an outstanding
// multiply/divide so that MFLO/MFHI can stall until the result arrives.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_stall        MEM-stage valid, upstream hold (combinational)
//   rt, rd, alu_out, mem_out,
//   addr_byte, pc              operand sources
//   Jal, RegDst, MemToReg, ExtrSigned, ExtrWord, LHToReg, LHWrite, RegWrite
//                              write-back controls
//   md_start, md_done,
//   md_lo, md_hi               multiply/divide issue and result
//   rf_we, rf_w, rf_din        registered GPR write port
//   lo_q, hi_q, md_pending     special registers and outstanding-op flag
module regfile_writeback_unit #(
    parameter int unsigned DATA_BITS     = 32,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned LINK_REG      = 31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_stall,
    input  logic [REG_ADDR_BITS-1:0] rt,
    input  logic [REG_ADDR_BITS-1:0] rd,
    input  logic [DATA_BITS-1:0]     alu_out,
    input  logic [DATA_BITS-1:0]     mem_out,
    input  logic [1:0]               addr_byte,
    input  logic [DATA_BITS-1:0]     pc,
    input  logic                     Jal,
    input  logic                     RegDst,
    input  logic                     MemToReg,
    input  logic                     ExtrSigned,
    input  logic [1:0]               ExtrWord,
    input  logic [1:0]               LHToReg,
    input  logic [1:0]               LHWrite,
    input  logic                     RegWrite,
    input  logic                     md_start,
    input  logic                     md_done,
    input  logic [DATA_BITS-1:0]     md_lo,
    input  logic [DATA_BITS-1:0]     md_hi,
    output logic                     rf_we,
    output logic [REG_ADDR_BITS-1:0] rf_w,
    output logic [DATA_BITS-1:0]     rf_din,
    output logic [DATA_BITS-1:0]     lo_q,
    output logic [DATA_BITS-1:0]     hi_q,
    output logic                     md_pending
);

    localparam int unsigned SH_BITS = $clog2(DATA_BITS);

    logic                     accept;
    logic                     mt_lo;
    logic                     mt_hi;
    logic                     lo_take;
    logic                     hi_take;
    // Set when an MT overwrote a register while its mult/div was still in
    // flight: the late md_done must then leave that register alone.
    logic                     lo_skip;
    logic                     hi_skip;
    logic                     lo_skip_next;
    logic                     hi_skip_next;
    logic                     pend_next;
    logic [DATA_BITS-1:0]     lo_next;
    logic [DATA_BITS-1:0]     hi_next;
    logic [7:0]               byte_f;
    logic [15:0]              half_f;
    logic [DATA_BITS-1:0]     ext_data;
    logic [DATA_BITS-1:0]     lh_data;
    logic [DATA_BITS-1:0]     wb_data;
    logic [REG_ADDR_BITS-1:0] wb_idx;
    logic                     we_next;

    // Hold an MFLO/MFHI only while its operand is pending and not arriving now.
    assign in_stall = in_valid & (LHToReg != 2'd0) & md_pending & ~md_done;
    assign accept   = in_valid & ~in_stall;
    assign mt_lo    = accept & LHWrite[0];
    assign mt_hi    = accept & LHWrite[1];
    assign lo_take  = md_done & ~lo_skip;
    assign hi_take  = md_done & ~hi_skip;

    // Write-back index and data selection, including load extraction.
    always_comb begin
        byte_f = mem_out[SH_BITS'({addr_byte, 3'b000}) +: 8];
        half_f = mem_out[SH_BITS'({addr_byte[1], 4'b0000}) +: 16];

        case (ExtrWord)
            2'd0:    ext_data = mem_out;
            2'd1:    ext_data = {{(DATA_BITS-8){ExtrSigned & byte_f[7]}}, byte_f};
            2'd2:    ext_data = {{(DATA_BITS-16){ExtrSigned & half_f[15]}}, half_f};
            default: ext_data = '0;
        endcase

        // md_done results are forwarded straight into a same-cycle MFLO/MFHI.
        case (LHToReg)
            2'd1:    lh_data = lo_take ? md_lo : lo_q;
            2'd2:    lh_data = hi_take ? md_hi : hi_q;
            default: lh_data = '0;
        endcase

        if (Jal)
            wb_data = pc;
        else if (MemToReg)
            wb_data = ext_data;
        else if (LHToReg != 2'd0)
            wb_data = lh_data;
        else
            wb_data = alu_out;

        if (Jal)
            wb_idx = REG_ADDR_BITS'(LINK_REG);
        else if (RegDst)
            wb_idx = rd;
        else
            wb_idx = rt;

        we_next = accept & (RegWrite | Jal) & (wb_idx != '0);
    end

    // LO/HI and outstanding-operation bookkeeping; MT has the final say.
    always_comb begin
        lo_next = lo_q;
        hi_next = hi_q;
        if (lo_take) lo_next = md_lo;
        if (hi_take) hi_next = md_hi;
        if (mt_lo)   lo_next = alu_out;
        if (mt_hi)   hi_next = alu_out;

        pend_next = md_pending;
        if (md_done | ((mt_lo | mt_hi) & md_pending)) pend_next = 1'b0;
        if (md_start) pend_next = 1'b1;

        lo_skip_next = lo_skip;
        hi_skip_next = hi_skip;
        if (md_done) begin
            lo_skip_next = 1'b0;
            hi_skip_next = 1'b0;
        end
        if (mt_lo & md_pending & ~md_done) lo_skip_next = 1'b1;
        if (mt_hi & md_pending & ~md_done) hi_skip_next = 1'b1;
        if (md_start) begin
            lo_skip_next = 1'b0;
            hi_skip_next = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_w       <= '0;
            rf_din     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            md_pending <= 1'b0;
            lo_skip    <= 1'b0;
            hi_skip    <= 1'b0;
        end else begin
            rf_we      <= we_next;
            if (accept) begin
                rf_w   <= wb_idx;
                rf_din <= wb_data;
            end
            lo_q       <= lo_next;
            hi_q       <= hi_next;
            md_pending <= pend_next;
            lo_skip    <= lo_skip_next;
            hi_skip    <= hi_skip_next;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Bench for regfile_writeback_unit: directed scenarios followed by random
// traffic, all checked against a behavioural model of the write-back rules.
module tb_regfile_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_stall;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] mem_out;
    logic [1:0]  addr_byte;
    logic [31:0] pc;
    logic        jal;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        extr_signed;
    logic [1:0]  extr_word;
    logic [1:0]  lh_to_reg;
    logic [1:0]  lh_write;
    logic        reg_write;
    logic        md_start;
    logic        md_done;
    logic [31:0] md_lo;
    logic [31:0] md_hi;
    logic        rf_we;
    logic [4:0]  rf_w;
    logic [31:0] rf_din;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        md_pending;

    int n_cmp;
    int n_bad;

    // Reference model state.
    logic [31:0] m_lo, m_hi, m_din;
    logic [4:0]  m_w;
    logic        m_we, m_pend;
    logic        m_lo_ignore_done, m_hi_ignore_done;
    logic        last_stall;

    regfile_writeback_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_stall   (in_stall),
        .rt         (rt),
        .rd         (rd),
        .alu_out    (alu_out),
        .mem_out    (mem_out),
        .addr_byte  (addr_byte),
        .pc         (pc),
        .Jal        (jal),
        .RegDst     (reg_dst),
        .MemToReg   (mem_to_reg),
        .ExtrSigned (extr_signed),
        .ExtrWord   (extr_word),
        .LHToReg    (lh_to_reg),
        .LHWrite    (lh_write),
        .RegWrite   (reg_write),
        .md_start   (md_start),
        .md_done    (md_done),
        .md_lo      (md_lo),
        .md_hi      (md_hi),
        .rf_we      (rf_we),
        .rf_w       (rf_w),
        .rf_din     (rf_din),
        .lo_q       (lo_q),
        .hi_q       (hi_q),
        .md_pending (md_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load extraction by plain arithmetic: shift, mask, subtract 2^n if negative.
    function automatic logic [31:0] ext_load(input logic [31:0] mem, input logic [1:0] b,
                                             input logic [1:0] w, input logic s);
        logic [31:0] f;
        case (w)
            2'd0: f = mem;
            2'd1: begin
                f = (mem >> (8 * b)) & 32'hFF;
                if (s && f >= 32'h80) f = f - 32'h100;
            end
            2'd2: begin
                f = (mem >> (16 * (b / 2))) & 32'hFFFF;
                if (s && f >= 32'h8000) f = f - 32'h10000;
            end
            default: f = 32'h0;
        endcase
        return f;
    endfunction

    task automatic model_reset();
        m_lo = 0; m_hi = 0; m_din = 0; m_w = 0; m_we = 0; m_pend = 0;
        m_lo_ignore_done = 0; m_hi_ignore_done = 0;
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic model_step(input logic stall);
        logic        acc;
        logic [4:0]  idx;
        logic [31:0] lo_src, hi_src, data;
        logic        lo_from_md, hi_from_md;
        acc        = in_valid && !stall;
        idx        = jal ? 5'd31 : (reg_dst ? rd : rt);
        lo_from_md = md_done && !m_lo_ignore_done;
        hi_from_md = md_done && !m_hi_ignore_done;
        lo_src     = lo_from_md ? md_lo : m_lo;
        hi_src     = hi_from_md ? md_hi : m_hi;
        if (jal)                 data = pc;
        else if (mem_to_reg)     data = ext_load(mem_out, addr_byte, extr_word, extr_signed);
        else if (lh_to_reg == 1) data = lo_src;
        else if (lh_to_reg == 2) data = hi_src;
        else if (lh_to_reg == 3) data = 0;
        else                     data = alu_out;
        m_we = acc && (reg_write || jal) && idx != 0;
        if (acc) begin
            m_w   = idx;
            m_din = data;
        end
        if (acc && lh_write[0])  m_lo = alu_out;
        else if (lo_from_md)     m_lo = md_lo;
        if (acc && lh_write[1])  m_hi = alu_out;
        else if (hi_from_md)     m_hi = md_hi;
        if (md_start || md_done) m_lo_ignore_done = 0;
        else if (acc && lh_write[0] && m_pend) m_lo_ignore_done = 1;
        if (md_start || md_done) m_hi_ignore_done = 0;
        else if (acc && lh_write[1] && m_pend) m_hi_ignore_done = 1;
        if (md_start) m_pend = 1;
        else if (md_done || (acc && lh_write != 0 && m_pend)) m_pend = 0;
    endtask

    // One clock: check the combinational stall, step the model, check outputs.
    task automatic cycle();
        logic exp_stall;
        #1;
        exp_stall  = in_valid && lh_to_reg != 0 && m_pend && !md_done;
        last_stall = in_stall;
        chk("in_stall", 32'(in_stall), 32'(exp_stall));
        model_step(exp_stall);
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_w", 32'(rf_w), 32'(m_w));
        chk("rf_din", rf_din, m_din);
        chk("lo_q", lo_q, m_lo);
        chk("hi_q", hi_q, m_hi);
        chk("md_pending", 32'(md_pending), 32'(m_pend));
    endtask

    task automatic clear_inputs();
        in_valid = 0; rt = 0; rd = 0; alu_out = 0; mem_out = 0; addr_byte = 0; pc = 0;
        jal = 0; reg_dst = 0; mem_to_reg = 0; extr_signed = 0; extr_word = 0;
        lh_to_reg = 0; lh_write = 0; reg_write = 0; md_start = 0; md_done = 0;
        md_lo = 0; md_hi = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we", 32'(rf_we), 32'h0);
        chk("reset_rf_din", rf_din, 32'h0);
        chk("reset_md_pending", 32'(md_pending), 32'h0);
        // md_done while held in reset is ignored.
        md_done = 1; md_lo = 32'h5; md_hi = 32'h6;
        @(posedge clk);
        #1;
        chk("reset_done_lo", lo_q, 32'h0);
        chk("reset_done_hi", hi_q, 32'h0);
        md_done = 0;
        rst_n = 1;

        // Signed and unsigned byte load from byte lane 2.
        in_valid = 1; reg_write = 1; mem_to_reg = 1; extr_word = 1; extr_signed = 1;
        addr_byte = 2; mem_out = 32'h1285_3456; rt = 8;
        cycle();
        chk("byte_signed_we", 32'(rf_we), 32'h1);
        chk("byte_signed_w", 32'(rf_w), 32'd8);
        chk("byte_signed", rf_din, 32'hFFFF_FF85);
        extr_signed = 0;
        cycle();
        chk("byte_unsigned", rf_din, 32'h0000_0085);

        // Signed halfword from the upper half (addr_byte[0] ignored).
        extr_word = 2; addr_byte = 3; extr_signed = 1; mem_out = 32'h8001_7FFF;
        cycle();
        chk("half_signed", rf_din, 32'hFFFF_8001);

        // Jal overrides RegDst and writes the link register.
        clear_inputs();
        in_valid = 1; jal = 1; reg_dst = 1; rd = 5; pc = 32'h0040_0010;
        cycle();
        chk("jal_w", 32'(rf_w), 32'd31);
        chk("jal_din", rf_din, 32'h0040_0010);

        // Writes to $0 are suppressed.
        clear_inputs();
        in_valid = 1; reg_write = 1; reg_dst = 1; rd = 0; alu_out = 32'h1111;
        cycle();
        chk("r0_we", 32'(rf_we), 32'h0);

        // No accept: rf_we drops and rf_w/rf_din hold.
        clear_inputs();
        cycle();
        chk("idle_we", 32'(rf_we), 32'h0);

        // MFLO stalls on a pending divide and is released by md_done.
        md_start = 1;
        cycle();
        md_start = 0;
        in_valid = 1; lh_to_reg = 1; reg_write = 1; reg_dst = 1; rd = 9;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("mflo_stalled", 32'(last_stall), 32'h1);
        end
        md_done = 1; md_lo = 32'h7; md_hi = 32'h3;
        cycle();
        chk("mflo_release", 32'(last_stall), 32'h0);
        chk("mflo_din", rf_din, 32'h7);
        chk("mflo_lo", lo_q, 32'h7);
        chk("mflo_pending", 32'(md_pending), 32'h0);

        // MTHI colliding with md_done: MT wins for HI, LO takes md_lo.
        clear_inputs();
        in_valid = 1; lh_write = 2; alu_out = 32'hAA; md_done = 1; md_hi = 32'hBB; md_lo = 32'hCC;
        cycle();
        chk("mthi_hi", hi_q, 32'hAA);
        chk("mthi_lo", lo_q, 32'hCC);

        // MTLO while pending clears pending; the late md_done skips LO only.
        clear_inputs();
        md_start = 1;
        cycle();
        clear_inputs();
        in_valid = 1; lh_write = 1; alu_out = 32'h55;
        cycle();
        chk("mt_pend_clear", 32'(md_pending), 32'h0);
        clear_inputs();
        md_done = 1; md_lo = 32'h99; md_hi = 32'h77;
        cycle();
        chk("late_done_lo", lo_q, 32'h55);
        chk("late_done_hi", hi_q, 32'h77);

        // Asynchronous reset with an operation pending and a write in flight.
        clear_inputs();
        md_start = 1;
        in_valid = 1; reg_write = 1; rt = 3; alu_out = 32'h1234;
        cycle();
        md_start = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("async_rf_we", 32'(rf_we), 32'h0);
        chk("async_pending", 32'(md_pending), 32'h0);
        chk("async_lo", lo_q, 32'h0);
        chk("async_hi", hi_q, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        clear_inputs();
        in_valid = 1; reg_write = 1; rt = 4; alu_out = 32'hCAFE;
        cycle();
        chk("post_reset_we", 32'(rf_we), 32'h1);
        chk("post_reset_din", rf_din, 32'hCAFE);

        // Random traffic; one outstanding mult/div at a time.
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom % 4) != 0;
            rt          = 5'($urandom);
            rd          = 5'($urandom);
            alu_out     = $urandom;
            mem_out     = $urandom;
            addr_byte   = 2'($urandom);
            pc          = $urandom;
            jal         = ($urandom % 8) == 0;
            reg_dst     = 1'($urandom);
            mem_to_reg  = ($urandom % 3) == 0;
            extr_signed = 1'($urandom);
            extr_word   = 2'($urandom);
            lh_to_reg   = (($urandom % 3) == 0) ? 2'($urandom) : 2'd0;
            lh_write    = (($urandom % 5) == 0) ? 2'($urandom) : 2'd0;
            reg_write   = ($urandom % 4) != 0;
            md_start    = !m_pend && (($urandom % 6) == 0);
            md_done     = ($urandom % 5) == 0;
            md_lo       = $urandom;
            md_hi       = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
